instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of main_decoder. It holds the fetch PC and issues word reads to instruction memory over a request/ready handshake. Returned instructions are buffered in a small FIFO and presented to decode, which takes opcode/funct3 from them, with valid/ready flow control. Branch/jump redirects from execute flush the buffer and restart fetch at the target.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_request  output  1  memory read request
fetch_address  output  32  word address of request, low 2 bits always 00
fetch_ready  input  1  memory completes request this cycle
fetch_data  input  32  instruction word, valid when fetch_ready=1
instruction_valid  output  1  FIFO head valid
instruction_ready  input  1  decode accepts head
instruction  output  32  head instruction word
instruction_PC  output  32  PC of head instruction
instruction_PC_plus4  output  32  instruction_PC + 4, modulo 2^32
redirect  input  1  branch taken / jump from execute
redirect_target  input  32  new PC, bits [1:0] ignored (forced 00)

Behaviour:
- Reset (reset=0, asynchronous): fetch_PC=RESET_PC, FIFO empty, state=IDLE, fetch_request=0, fetch_address=RESET_PC, instruction_valid=0, instruction/instruction_PC=0.
- FSM states: IDLE, WAIT, DISCARD.
- IDLE: if FIFO has free entry and redirect=0 -> fetch_request=1, fetch_address=fetch_PC, go WAIT. Else stay.
- WAIT: fetch_request=1 and fetch_address held stable until fetch_ready=1.
  - On fetch_ready=1 with redirect=0: push {fetch_PC, fetch_data}, fetch_PC+=4, go IDLE.
  - redirect=1 with fetch_ready=0: go DISCARD, fetch_PC=target.
  - redirect=1 with fetch_ready=1: drop data, fetch_PC=target, go IDLE.
- DISCARD: request and address held stable (old address) until fetch_ready=1. Returned data dropped, then go IDLE. Further redirects in DISCARD update fetch_PC only.
- Request throughput: at most one outstanding request. Minimum 2 cycles per fetch (IDLE->WAIT->IDLE). Memory latency from request to earliest fetch_ready is 0 cycles, i.e. same cycle as request assertion.
- FIFO: instruction_valid = (count>0). Pop when instruction_valid & instruction_ready. Push and pop in the same cycle are allowed when full (count unchanged). IDLE sees space using count before the pop.
- Full: no new request issued. An in-flight request can only exist if space was reserved at issue, so no overflow is possible.
- Empty: instruction_valid=0. Outputs hold the last value and must not be trusted.
- redirect=1 (any state): FIFO flushed same edge (count=0). Redirect has priority over push and pop in that cycle. instruction_valid=0 on the next cycle.
- PC arithmetic: 32-bit, wraps 32'hFFFFFFFC -> 32'h00000000.
- instruction_* outputs are registered FIFO head, with no combinational path from fetch_data.

Test Plan:
- Reset mid-WAIT (reset low while fetch_request=1) -> next cycle fetch_request=0, instruction_valid=0. After release, first request is at fetch_address=32'h00000000.
- Memory with 1-cycle latency returns 32'h00000013, 32'h00500093, 32'h00A00113; instruction_ready=1 -> decode sees them with instruction_PC 0, 4, 8 and PC_plus4 4, 8, 12.
- instruction_ready=0 held -> after 2 fetches instruction_valid=1, fetch_request stays 0 (full). Raise ready for 1 cycle -> exactly one pop and one new request.
- redirect=1, target=32'h00000103 while in WAIT (memory latency 3) -> FIFO flushed. Old response discarded, not pushed. Next fetch_address=32'h00000100, and the head is later instruction_PC=32'h00000100.
- redirect coincident with fetch_ready and a pop -> no push, no extra pop, count=0. Next fetch at target.
- Start at PC 32'hFFFFFFF8 (via redirect) -> fetched PCs FFFFFFF8, FFFFFFFC, 00000000. PC_plus4 of FFFFFFFC is 00000000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the fetch PC, reads instruction words over request/ready, buffers them for decode.
// Latency: a request is raised the cycle after IDLE sees space; a returned word reaches decode one cycle later.
// Backpressure: no request is issued while the buffer is full; decode stalls via instruction_ready; redirect flushes.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        fetch_request,
  output logic [31:0] fetch_address,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_PC,
  output logic [31:0] instruction_PC_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   target_pc;

  entry_t        entry_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          has_space;
  logic          push;
  logic          pop;

  // Redirect targets are word aligned regardless of the low bits supplied.
  assign target_pc = redirect_target & 32'hFFFF_FFFC;

  // Space is judged on the occupancy before this cycle's pop, so a full buffer never issues.
  assign has_space = (count < CW'(FIFO_DEPTH));

  // A response is kept only when it belongs to a live request and no redirect kills it.
  assign push = (state == WAIT) && fetch_ready && !redirect;
  assign pop  = instruction_valid && instruction_ready && !redirect;

  assign instruction_valid    = (count != '0);
  assign instruction          = entry_mem[rd_ptr].word;
  assign instruction_PC       = entry_mem[rd_ptr].pc;
  assign instruction_PC_plus4 = entry_mem[rd_ptr].pc + 32'd4;

  // Fetch FSM: issues one request at a time and tracks whether its response is still wanted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      fetch_request <= 1'b0;
      fetch_address <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end else if (has_space) begin
            fetch_request <= 1'b1;
            fetch_address <= fetch_pc;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (fetch_ready) begin
            fetch_request <= 1'b0;
            state         <= IDLE;
            fetch_pc      <= redirect ? target_pc : fetch_pc + 32'd4;
          end else if (redirect) begin
            fetch_pc <= target_pc;
            state    <= DISCARD;
          end
        end
        DISCARD: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end
          if (fetch_ready) begin
            fetch_request <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          fetch_request <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Instruction buffer: redirect empties it and wins over any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entry_mem[i] <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entry_mem[wr_ptr] <= '{pc: fetch_pc, word: fetch_data};
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
